// File: rtl/fpu_div_pkg.sv
// Shared constants and types for the sequential single-precision divider.
// Subnormals are treated as zero throughout; NaN is always the quiet pattern {s,FF,400000}.
package fpu_div_pkg;

   localparam int MAN_W = 24;
   localparam int REM_W = 25;
   localparam int BIAS  = 127;

   localparam logic [7:0]  EXP_ZERO = 8'h00;
   localparam logic [7:0]  EXP_INF  = 8'hFF;
   localparam logic [23:0] MAN_NAN  = 24'hC00000;
   localparam logic [23:0] MAN_ZERO = 24'h800000;

   typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} div_state_e;

   // Plain-vector aliases of the state encoding for the register itself.
   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_CALC = CALC;
   localparam logic [1:0] ST_NORM = NORM;
   localparam logic [1:0] ST_DONE = DONE;

endpackage

// File: rtl/fpu_div_seq_iter.sv
// One radix-2 restoring division step.
// The partial remainder never reaches 2*mb, so doubling it always fits in REM_W bits.
module DIV_MAN_iter
   import fpu_div_pkg::*;
(
   input  logic [REM_W-1:0] i_rem,
   input  logic [MAN_W-1:0] i_mb,
   output logic [REM_W-1:0] o_rem,
   output logic             o_q_bit
);

   logic [REM_W-1:0] diff;

   always_comb begin
      diff    = i_rem - {1'b0, i_mb};
      o_q_bit = (i_rem >= {1'b0, i_mb});
      o_rem   = (o_q_bit ? diff : i_rem) << 1;
   end

endmodule

// File: rtl/fpu_div_seq.sv
// Sequential IEEE-754 single-precision divider, one quotient bit per clock.
// Special operands bypass the iteration and are answered the cycle after acceptance.
module fpu_div_seq
   import fpu_div_pkg::*;
#(
   parameter int SIZE_DATA = 32,
   parameter int SIZE_ITER = 26
)(
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [SIZE_DATA-1:0] i_32_a,
   input  logic [SIZE_DATA-1:0] i_32_b,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [SIZE_DATA-1:0] o_32_div,
   output logic                 o_div_by_zero
);

   localparam logic signed [9:0] BIAS_E = 10'(BIAS);
   localparam logic [4:0]        CNT_LAST = 5'(SIZE_ITER - 1);

   logic [1:0]              state_q, state_d;
   logic [4:0]              cnt_q, cnt_d;
   logic                    sign_q, sign_d;
   logic [MAN_W-1:0]        mb_q, mb_d;
   logic [REM_W-1:0]        rem_q, rem_d;
   logic [SIZE_ITER-1:0]    quo_q, quo_d;
   logic signed [9:0]       exp_q, exp_d;
   logic [SIZE_DATA-1:0]    res_q, res_d;
   logic                    dbz_q, dbz_d;

   logic [REM_W-1:0]        rem_next;
   logic                    q_bit;

   logic [7:0]              exp_a, exp_b;
   logic [22:0]             frac_a, frac_b;
   logic                    sign_n;
   logic                    a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

   logic signed [9:0]       exp_n;
   logic [22:0]             frac_n, frac_rnd;
   logic                    rb, carry;

   DIV_MAN_iter u_iter (
      .i_rem   (rem_q),
      .i_mb    (mb_q),
      .o_rem   (rem_next),
      .o_q_bit (q_bit)
   );

   always_comb begin
      exp_a  = i_32_a[30:23];
      exp_b  = i_32_b[30:23];
      frac_a = i_32_a[22:0];
      frac_b = i_32_b[22:0];
      sign_n = i_32_a[31] ^ i_32_b[31];
      a_zero = (exp_a == EXP_ZERO);
      b_zero = (exp_b == EXP_ZERO);
      a_inf  = (exp_a == EXP_INF) && (frac_a == '0);
      b_inf  = (exp_b == EXP_INF) && (frac_b == '0);
      a_nan  = (exp_a == EXP_INF) && (frac_a != '0);
      b_nan  = (exp_b == EXP_INF) && (frac_b != '0);
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sign_d   = sign_q;
      mb_d     = mb_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      exp_d    = exp_q;
      res_d    = res_q;
      dbz_d    = dbz_q;
      exp_n    = '0;
      frac_n   = '0;
      frac_rnd = '0;
      rb       = 1'b0;
      carry    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (i_valid) begin
               sign_d  = sign_n;
               mb_d    = {1'b1, frac_b};
               rem_d   = {2'b01, frac_a};
               exp_d   = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b});
               cnt_d   = '0;
               quo_d   = '0;
               dbz_d   = 1'b0;
               state_d = ST_DONE;
               // Class priority matters: NaN-producing cases first, then infinities, then zeros.
               if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                  res_d = {sign_n, EXP_INF, MAN_NAN[22:0]};
               end else if (a_inf) begin
                  res_d = {sign_n, EXP_INF, MAN_ZERO[22:0]};
               end else if (b_zero) begin
                  res_d = {sign_n, EXP_INF, MAN_ZERO[22:0]};
                  dbz_d = 1'b1;
               end else if (a_zero || b_inf) begin
                  res_d = {sign_n, EXP_ZERO, MAN_ZERO[22:0]};
               end else begin
                  state_d = ST_CALC;
               end
            end
         end

         ST_CALC: begin
            rem_d = rem_next;
            quo_d = {quo_q[SIZE_ITER-2:0], q_bit};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_NORM;
            end
         end

         ST_NORM: begin
            // The hidden bit is always set, so a carry out of the fraction means mantissa 2.0.
            if (quo_q[25]) begin
               frac_n = quo_q[24:2];
               rb     = quo_q[1];
               exp_n  = exp_q + BIAS_E;
            end else begin
               frac_n = quo_q[23:1];
               rb     = quo_q[0];
               exp_n  = exp_q + BIAS_E - 10'sd1;
            end
            {carry, frac_rnd} = {1'b0, frac_n} + {23'd0, rb};
            if (carry) begin
               frac_rnd = MAN_ZERO[22:0];
               exp_n    = exp_n + 10'sd1;
            end
            if (exp_n >= 10'sd255) begin
               res_d = {sign_q, EXP_INF, MAN_ZERO[22:0]};
            end else if (exp_n <= 10'sd0) begin
               res_d = {sign_q, EXP_ZERO, MAN_ZERO[22:0]};
            end else begin
               res_d = {sign_q, exp_n[7:0], frac_rnd};
            end
            state_d = ST_DONE;
         end

         ST_DONE: begin
            if (i_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         sign_q  <= 1'b0;
         mb_q    <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         exp_q   <= '0;
         res_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sign_q  <= sign_d;
         mb_q    <= mb_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         exp_q   <= exp_d;
         res_q   <= res_d;
         dbz_q   <= dbz_d;
      end
   end

   assign o_ready       = (state_q == ST_IDLE);
   assign o_valid       = (state_q == ST_DONE);
   assign o_32_div      = res_q;
   assign o_div_by_zero = dbz_q;

endmodule
